tlc_conflict_monitor: RTL
=========================

Name: tlc_conflict_monitor

Overview:
- Passive checker on the lamp outputs of the traffic light controller: samples North/East/South/West LED buses and verifies encoding, axis conflict and phase sequencing.
- Latches the first violation with a code and direction and requests fail-safe flash until cleared.
- Sits beside the controller at the top level; it reads what the controller writes and never drives the lamps itself.

Parameters:
MIN_YELLOW_CYC, 4, minimum consecutive yellow cycles before red
MIN_RED_CLEAR, 2, minimum consecutive all-red cycles before the opposing axis may go green
STUCK_CYC, 1024, no-change watchdog limit; used only with TLC_MON_STUCK_EN

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
North_LEDs  in  3  {red,yellow,green}, bit2=red, bit1=yellow, bit0=green
East_LEDs  in  3  same encoding
South_LEDs  in  3  same encoding
West_LEDs  in  3  same encoding
enable  in  1  1 = faults may latch; 0 = track only
fault_clear  in  1  single-cycle clear request
fault  out  1  latched fault flag
fault_code  out  3  cause of the latched fault
fault_dir  out  2  offending direction: N=0, E=1, S=2, W=3
flash_req  out  1  equals fault; requests red flash
fault_count  out  8  number of latched fault events, saturates at 255

Behaviour:
- Reset: fault=0, fault_code=0, fault_dir=0, flash_req=0, fault_count=0. All counters and history registers clear. first_sample flag set.
- Sampling and latency: all four LED buses are registered at edge N. Checks run on the registered value, and fault/code/dir update at edge N+1.
- Axes: NS = {N,S}, EW = {E,W}. A direction is "open" when its LED bus is not 100.
- Check codes (lowest code wins; fault_dir = lowest-index offending direction):
  - 1 ILLEGAL_ENC: bus not one-hot (000 or more than one bit set).
  - 2 CONFLICT: any NS direction open while any EW direction is open.
  - 3 SKIP_YELLOW: a direction goes green->red in one sample.
  - 4 SHORT_YELLOW: a direction goes yellow->red after fewer than MIN_YELLOW_CYC yellow samples.
  - 5 SHORT_CLEAR: a direction goes red->green when last_axis is the opposite axis and the all-red counter is < MIN_RED_CLEAR.
  - 6 BAD_ORDER: red->yellow, or yellow->green.
  - 7 STUCK: optional, see below.
- Per-direction yellow counter: counts consecutive yellow samples, resets on non-yellow, saturates at MIN_YELLOW_CYC.
- All-red counter: counts consecutive samples with all four red, saturates at MIN_RED_CLEAR; reset value is MIN_RED_CLEAR.
- last_axis: updates to the axis of any open direction; holds while all red; reset value NS.
- First sample after reset: checks 3-6 are masked; history loads from that sample. Checks 1-2 are active immediately.
- Latch:
  - When fault=0, enable=1 and any check fires, fault=1, code/dir are captured and fault_count increments (saturating).
  - While fault=1, new violations are ignored and neither count nor code changes.
- Clear:
  - fault_clear with fault=1 drops fault at the next edge.
  - If a check fires in the same cycle as the clear, fault stays 1, the new code/dir are loaded and the count increments.
  - fault_clear with fault=0 has no effect.
- enable=0: trackers and counters keep updating and no new latch occurs. A fault already latched stays latched.
- Reset mid-operation clears everything asynchronously; the first-sample mask re-applies.

Optional Feature:
- TLC_MON_STUCK_EN defined: a watchdog counts samples with all four buses unchanged and restarts on any change. Reaching STUCK_CYC fires code 7 with fault_dir=0. Counter width is clog2(STUCK_CYC+1), saturating.
- Undefined: no watchdog logic and code 7 is never produced.

Test Plan:
- Legal cycle, NS green 5 / yellow 4 / all-red 2 / EW green 5 / yellow 4 / all-red 2, repeated 3x -> fault=0, fault_count=0.
- N=001 and E=001 simultaneously -> fault=1 one edge after the sampling edge, fault_code=2, fault_dir=0, flash_req=1, fault_count=1.
- S yellow for 2 samples then red -> fault_code=4, fault_dir=2; a later conflict does not change code or count.
- NS to all-red for 1 sample, then W green -> fault_code=5, fault_dir=3. Pulse fault_clear with legal lamps -> fault=0 next edge, fault_count stays 1.
- E=011 with enable=0 -> fault=0. Raise enable with the pattern held -> fault_code=1, fault_dir=1. Assert reset mid-fault -> all outputs 0 immediately.
- With TLC_MON_STUCK_EN and STUCK_CYC=16, hold all-red 16 samples -> fault_code=7. Without the macro, hold all-red 2000 samples -> fault=0.

Source files
------------

// File: rtl/tlc_conflict_monitor.sv
// rtl/tlc_conflict_monitor.sv - passive lamp-output checker for the traffic light controller.
// Optional no-change watchdog (code 7) enabled by defining TLC_MON_STUCK_EN.
module tlc_conflict_monitor #(
  parameter int MIN_YELLOW_CYC = 4,
  parameter int MIN_RED_CLEAR  = 2
`ifdef TLC_MON_STUCK_EN
  , parameter int STUCK_CYC    = 1024
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] North_LEDs,
  input  logic [2:0] East_LEDs,
  input  logic [2:0] South_LEDs,
  input  logic [2:0] West_LEDs,
  input  logic       enable,
  input  logic       fault_clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir,
  output logic       flash_req,
  output logic [7:0] fault_count
);

  localparam logic [2:0] LED_R = 3'b100;
  localparam logic [2:0] LED_Y = 3'b010;
  localparam logic [2:0] LED_G = 3'b001;
  localparam int YW = $clog2(MIN_YELLOW_CYC + 1);
  localparam int RW = $clog2(MIN_RED_CLEAR + 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MIN_YELLOW_CYC);
  localparam logic [RW-1:0] R_MAX = RW'(MIN_RED_CLEAR);
  // Axis of each direction index: N=0,E=1,S=2,W=3 -> EW directions carry a 1.
  localparam logic [3:0] DIR_AXIS = 4'b1010;

  logic [3:0][2:0]    led_q, led_d;
  logic [3:0][2:0]    prev_q, prev_d;
  logic [3:0][YW-1:0] yel_q, yel_d;
  logic [RW-1:0]      red_q, red_d;
  logic               vld_q, vld_d;
  logic               first_q, first_d;
  logic               axis_q, axis_d;
  logic               fault_q, fault_d;
  logic [2:0]         code_q, code_d;
  logic [1:0]         dir_q, dir_d;
  logic [7:0]         cnt_q, cnt_d;

  logic [3:0] dir_open;
  logic       ns_open, ew_open, all_red, trans_ok;
  logic [3:0] enc_hit, cfl_hit, skip_hit, shy_hit, shc_hit, ord_hit;
  logic       stuck_hit;
  logic       chk_fire;
  logic [2:0] chk_code;
  logic [1:0] chk_dir;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd3;
  endfunction

  always_comb begin
    dir_open = '0;
    enc_hit  = '0;
    cfl_hit  = '0;
    skip_hit = '0;
    shy_hit  = '0;
    shc_hit  = '0;
    ord_hit  = '0;
    for (int d = 0; d < 4; d++) begin
      dir_open[d] = (led_q[d] != LED_R);
    end
    ns_open  = dir_open[0] | dir_open[2];
    ew_open  = dir_open[1] | dir_open[3];
    all_red  = ~|dir_open;
    // Transition checks need a previous sample to compare against.
    trans_ok = vld_q & ~first_q;
    for (int d = 0; d < 4; d++) begin
      enc_hit[d]  = vld_q & ~((led_q[d] == LED_R) | (led_q[d] == LED_Y) | (led_q[d] == LED_G));
      cfl_hit[d]  = vld_q & ns_open & ew_open & dir_open[d];
      skip_hit[d] = trans_ok & (prev_q[d] == LED_G) & (led_q[d] == LED_R);
      shy_hit[d]  = trans_ok & (prev_q[d] == LED_Y) & (led_q[d] == LED_R) & (yel_q[d] < Y_MAX);
      shc_hit[d]  = trans_ok & (prev_q[d] == LED_R) & (led_q[d] == LED_G) &
                    (axis_q != DIR_AXIS[d]) & (red_q < R_MAX);
      ord_hit[d]  = trans_ok & (((prev_q[d] == LED_R) & (led_q[d] == LED_Y)) |
                                ((prev_q[d] == LED_Y) & (led_q[d] == LED_G)));
    end
  end

`ifdef TLC_MON_STUCK_EN
  localparam int SW = $clog2(STUCK_CYC + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STUCK_CYC);

  logic [SW-1:0] stuck_q, stuck_d, stuck_len;

  // Run length includes the current sample, so a fresh or changed sample counts as 1.
  always_comb begin
    if (first_q || (led_q != prev_q)) begin
      stuck_len = SW'(1);
    end else if (stuck_q == S_MAX) begin
      stuck_len = stuck_q;
    end else begin
      stuck_len = stuck_q + SW'(1);
    end
    stuck_d   = vld_q ? stuck_len : stuck_q;
    stuck_hit = vld_q & (stuck_len >= S_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stuck_q <= '0;
    end else begin
      stuck_q <= stuck_d;
    end
  end
`else
  assign stuck_hit = 1'b0;
`endif

  always_comb begin
    chk_code = 3'd0;
    chk_dir  = 2'd0;
    if (|enc_hit) begin
      chk_code = 3'd1;
      chk_dir  = lowest(enc_hit);
    end else if (|cfl_hit) begin
      chk_code = 3'd2;
      chk_dir  = lowest(cfl_hit);
    end else if (|skip_hit) begin
      chk_code = 3'd3;
      chk_dir  = lowest(skip_hit);
    end else if (|shy_hit) begin
      chk_code = 3'd4;
      chk_dir  = lowest(shy_hit);
    end else if (|shc_hit) begin
      chk_code = 3'd5;
      chk_dir  = lowest(shc_hit);
    end else if (|ord_hit) begin
      chk_code = 3'd6;
      chk_dir  = lowest(ord_hit);
    end else if (stuck_hit) begin
      chk_code = 3'd7;
      chk_dir  = 2'd0;
    end
    chk_fire = (chk_code != 3'd0);
  end

  always_comb begin
    led_d   = {West_LEDs, South_LEDs, East_LEDs, North_LEDs};
    vld_d   = 1'b1;
    prev_d  = prev_q;
    yel_d   = yel_q;
    red_d   = red_q;
    axis_d  = axis_q;
    first_d = first_q;
    if (vld_q) begin
      prev_d  = led_q;
      first_d = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (led_q[d] != LED_Y) begin
          yel_d[d] = '0;
        end else if (yel_q[d] != Y_MAX) begin
          yel_d[d] = yel_q[d] + YW'(1);
        end
      end
      if (!all_red) begin
        red_d = '0;
      end else if (red_q != R_MAX) begin
        red_d = red_q + RW'(1);
      end
      if (ns_open) begin
        axis_d = 1'b0;
      end else if (ew_open) begin
        axis_d = 1'b1;
      end
    end
  end

  // A clear coinciding with a fresh violation reloads instead of dropping the flag.
  always_comb begin
    fault_d = fault_q;
    code_d  = code_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (enable && chk_fire && (!fault_q || fault_clear)) begin
      fault_d = 1'b1;
      code_d  = chk_code;
      dir_d   = chk_dir;
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (fault_q && fault_clear) begin
      fault_d = 1'b0;
      code_d  = 3'd0;
      dir_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= {4{LED_R}};
      prev_q  <= {4{LED_R}};
      yel_q   <= '0;
      red_q   <= R_MAX;
      vld_q   <= 1'b0;
      first_q <= 1'b1;
      axis_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      dir_q   <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      led_q   <= led_d;
      prev_q  <= prev_d;
      yel_q   <= yel_d;
      red_q   <= red_d;
      vld_q   <= vld_d;
      first_q <= first_d;
      axis_q  <= axis_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fault       = fault_q;
  assign flash_req   = fault_q;
  assign fault_code  = code_q;
  assign fault_dir   = dir_q;
  assign fault_count = cnt_q;

endmodule
